// File: rtl/robot_pkg.sv
// Shared definitions for the robot navigation/action path: mode codes,
// executor FSM states, done-flag layout and default tuning constants.
package robot_pkg;

  typedef enum logic [2:0] {
    MODE_STOP   = 3'b000,
    MODE_SEARCH = 3'b001,
    MODE_LEFT   = 3'b010,
    MODE_RIGHT  = 3'b011,
    MODE_RED    = 3'b100,
    MODE_BLUE   = 3'b101,
    MODE_GREEN  = 3'b110,
    MODE_PAUSE  = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_TIMED,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic green;
    logic blue;
    logic red;
    logic turn_r;
    logic turn_l;
  } done_t;

  localparam int unsigned DEF_PWM_BITS       = 8;
  localparam logic [7:0]  DEF_DUTY_SEARCH    = 8'd160;
  localparam logic [7:0]  DEF_DUTY_TURN      = 8'd128;
  localparam int unsigned DEF_TIMER_BITS     = 24;
  localparam logic [23:0] DEF_TURN_CYCLES    = 24'd5_000_000;
  localparam logic [23:0] DEF_DISPLAY_CYCLES = 24'd10_000_000;

  function automatic state_e mode_class(input mode_e m);
    state_e s;
    case (m)
      MODE_STOP, MODE_PAUSE: s = ST_IDLE;
      MODE_SEARCH:           s = ST_RUN;
      default:               s = ST_TIMED;
    endcase
    return s;
  endfunction

  function automatic logic is_turn(input mode_e m);
    return (m == MODE_LEFT) || (m == MODE_RIGHT);
  endfunction

  function automatic done_t done_for(input mode_e m);
    done_t d;
    d = '0;
    case (m)
      MODE_LEFT:  d.turn_l = 1'b1;
      MODE_RIGHT: d.turn_r = 1'b1;
      MODE_RED:   d.red    = 1'b1;
      MODE_BLUE:  d.blue   = 1'b1;
      MODE_GREEN: d.green  = 1'b1;
      default:    d        = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter shared by both motor channels, with one
// comparator per channel. All-ones duty is forced to a constant high.
module pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] i_duty_a,
  input  logic [PWM_BITS-1:0] i_duty_b,
  output logic                o_pwm_a,
  output logic                o_pwm_b
);

  logic [PWM_BITS-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A plain compare can never be true for every count, so full duty is special-cased.
  assign o_pwm_a = (i_duty_a == '1) ? 1'b1 : (r_cnt < i_duty_a);
  assign o_pwm_b = (i_duty_b == '1) ? 1'b1 : (r_cnt < i_duty_b);

endmodule

// File: rtl/robot_action_executor.sv
// Turns the navigation mode code into motor PWM/direction and LED drive,
// timing turns and colour displays and pulsing a done flag when each ends.
module robot_action_executor
  import robot_pkg::*;
#(
  parameter int unsigned             PWM_BITS       = DEF_PWM_BITS,
  parameter logic [PWM_BITS-1:0]     DUTY_SEARCH    = PWM_BITS'(DEF_DUTY_SEARCH),
  parameter logic [PWM_BITS-1:0]     DUTY_TURN      = PWM_BITS'(DEF_DUTY_TURN),
  parameter int unsigned             TIMER_BITS     = DEF_TIMER_BITS,
  parameter logic [TIMER_BITS-1:0]   TURN_CYCLES    = TIMER_BITS'(DEF_TURN_CYCLES),
  parameter logic [TIMER_BITS-1:0]   DISPLAY_CYCLES = TIMER_BITS'(DEF_DISPLAY_CYCLES)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] mode,
  output logic       motor_l_pwm,
  output logic       motor_r_pwm,
  output logic       motor_l_dir,
  output logic       motor_r_dir,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       turn_l_done,
  output logic       turn_r_done,
  output logic       red_done,
  output logic       blue_done,
  output logic       green_done
);

  localparam logic [TIMER_BITS-1:0] TURN_LAST    = TURN_CYCLES - 1'b1;
  localparam logic [TIMER_BITS-1:0] DISPLAY_LAST = DISPLAY_CYCLES - 1'b1;

  mode_e                 r_mode_q;
  state_e                r_state;
  logic [TIMER_BITS-1:0] r_timer;
  done_t                 r_done_evt;

  mode_e                 w_mode;
  logic                  w_change;
  logic [TIMER_BITS-1:0] w_last;
  logic [PWM_BITS-1:0]   w_duty;
  logic                  w_dir_l;
  logic                  w_dir_r;
  logic                  w_lit;
  logic                  w_pwm_l;
  logic                  w_pwm_r;

  assign w_mode   = mode_e'(mode);
  assign w_change = (w_mode != r_mode_q);
  assign w_last   = is_turn(r_mode_q) ? TURN_LAST : DISPLAY_LAST;

  // Output decode from the current state; registered below, hence the 2-clock latency.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_duty  = '0;
    w_dir_l = 1'b1;
    w_dir_r = 1'b1;
    w_lit   = 1'b0;
    case (r_state)
      ST_RUN: w_duty = DUTY_SEARCH;
      ST_TIMED: begin
        w_lit = !is_turn(r_mode_q);
        if (r_mode_q == MODE_LEFT) begin
          w_duty  = DUTY_TURN;
          w_dir_l = 1'b0;
        end else if (r_mode_q == MODE_RIGHT) begin
          w_duty  = DUTY_TURN;
          w_dir_r = 1'b0;
        end
      end
      ST_HOLD: w_lit = !is_turn(r_mode_q);
      default: w_lit = 1'b0;
    endcase
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clock    (clock),
    .reset    (reset),
    .i_duty_a (w_duty),
    .i_duty_b (w_duty),
    .o_pwm_a  (w_pwm_l),
    .o_pwm_b  (w_pwm_r)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode_q    <= MODE_STOP;
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_done_evt  <= '0;
      motor_l_pwm <= 1'b0;
      motor_r_pwm <= 1'b0;
      motor_l_dir <= 1'b1;
      motor_r_dir <= 1'b1;
      led_r       <= 1'b0;
      led_g       <= 1'b0;
      led_b       <= 1'b0;
      turn_l_done <= 1'b0;
      turn_r_done <= 1'b0;
      red_done    <= 1'b0;
      blue_done   <= 1'b0;
      green_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every decode below sees the pre-edge state.
      r_mode_q   <= w_mode;
      r_done_evt <= '0;

      // A change always wins over the terminal count, aborting any pending done.
      if (w_change) begin
        r_state <= mode_class(w_mode);
        r_timer <= '0;
      end else if (r_state == ST_TIMED) begin
        if (r_timer == w_last) begin
          r_state    <= ST_HOLD;
          r_done_evt <= done_for(r_mode_q);
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end

      motor_l_pwm <= w_pwm_l;
      motor_r_pwm <= w_pwm_r;
      motor_l_dir <= w_dir_l;
      motor_r_dir <= w_dir_r;
      led_r       <= w_lit && (r_mode_q == MODE_RED);
      led_g       <= w_lit && (r_mode_q == MODE_GREEN);
      led_b       <= w_lit && (r_mode_q == MODE_BLUE);
      turn_l_done <= r_done_evt.turn_l;
      turn_r_done <= r_done_evt.turn_r;
      red_done    <= r_done_evt.red;
      blue_done   <= r_done_evt.blue;
      green_done  <= r_done_evt.green;
    end
  end

endmodule

// File: tb/tb_robot_action_executor.sv
// Directed bench for robot_action_executor: expected done pulses are queued
// with their cycle of arrival and matched by an independent monitor.
module tb_robot_action_executor;

  localparam int TURN    = 20;
  localparam int DISPLAY = 30;
  localparam logic [11:0] RESET_VEC = 12'b00_11_000_00000;

  logic       clock;
  logic       reset;
  logic [2:0] mode;
  logic       motor_l_pwm, motor_r_pwm, motor_l_dir, motor_r_dir;
  logic       led_r, led_g, led_b;
  logic       turn_l_done, turn_r_done, red_done, blue_done, green_done;

  typedef struct {
    logic [4:0] vec;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  robot_action_executor #(
    .PWM_BITS       (4),
    .DUTY_SEARCH    (4'd12),
    .DUTY_TURN      (4'd8),
    .TIMER_BITS     (24),
    .TURN_CYCLES    (24'd20),
    .DISPLAY_CYCLES (24'd30)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .motor_l_pwm (motor_l_pwm),
    .motor_r_pwm (motor_r_pwm),
    .motor_l_dir (motor_l_dir),
    .motor_r_dir (motor_r_dir),
    .led_r       (led_r),
    .led_g       (led_g),
    .led_b       (led_b),
    .turn_l_done (turn_l_done),
    .turn_r_done (turn_r_done),
    .red_done    (red_done),
    .blue_done   (blue_done),
    .green_done  (green_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [4:0] done_vec();
    return {green_done, blue_done, red_done, turn_r_done, turn_l_done};
  endfunction

  function automatic logic [11:0] outs();
    return {motor_l_pwm, motor_r_pwm, motor_l_dir, motor_r_dir,
            led_r, led_g, led_b, done_vec()};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge: the next posedge is the first one to sample the new mode.
  task automatic set_mode(input logic [2:0] m, input logic [4:0] exp_done, input int len);
    exp_t e;
    mode = m;
    if (exp_done != 5'b0) begin
      e.vec = exp_done;
      e.cyc = cyc + 1 + len + 1;
      q.push_back(e);
    end
  endtask

  // Monitor: every done pulse must match the head of the expectation queue.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done_vec() != 5'b0) begin
      if (q.size() == 0) begin
        check("unexpected_done", {27'b0, done_vec()}, 32'd0);
      end else begin
        e = q.pop_front();
        check("done_vec", {27'b0, done_vec()}, {27'b0, e.vec});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    int hi_l;
    int hi_r;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    mode     = 3'b000;
    tick(3);
    check("reset_outs", {20'b0, outs()}, {20'b0, RESET_VEC});
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (outs() !== RESET_VEC) bad++;
    end
    check("idle_hold_100", bad, 0);

    // Search: 12/16 duty on both motors, forward.
    set_mode(3'b001, 5'b0, 0);
    tick(1);
    check("search_lag_pwm", {30'b0, motor_l_pwm, motor_r_pwm}, 32'd0);
    hi_l = 0; hi_r = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      hi_l += motor_l_pwm;
      hi_r += motor_r_pwm;
      if (!motor_l_dir || !motor_r_dir) bad++;
    end
    check("search_pwm_l", hi_l, 12);
    check("search_pwm_r", hi_r, 12);
    check("search_dir", bad, 0);
    tick(200);

    // Left turn: 20 active cycles, done at +21, then held quiet.
    set_mode(3'b010, 5'b00001, TURN);
    tick(1);
    check("left_lag_dir", {31'b0, motor_l_dir}, 32'd1);
    hi_l = 0; hi_r = 0; bad = 0;
    for (int i = 0; i < TURN; i++) begin
      tick(1);
      if (motor_l_dir !== 1'b0 || motor_r_dir !== 1'b1) bad++;
      if (i < 16) begin
        hi_l += motor_l_pwm;
        hi_r += motor_r_pwm;
      end
    end
    check("left_dir_20", bad, 0);
    check("left_pwm_l", hi_l, 8);
    check("left_pwm_r", hi_r, 8);
    tick(1);
    check("left_hold_outs", {20'b0, outs() & 12'hFE0}, {20'b0, RESET_VEC});
    tick(100);
    check("left_no_repeat", q.size(), 0);

    // Blue: LED stays lit through HOLD until the mode changes.
    set_mode(3'b101, 5'b01000, DISPLAY);
    tick(1);
    check("blue_lag", {31'b0, led_b}, 32'd0);
    tick(1);
    check("blue_on", {31'b0, led_b}, 32'd1);
    bad = 0;
    for (int i = 0; i < 140; i++) begin
      tick(1);
      if (led_b !== 1'b1 || motor_l_pwm || motor_r_pwm || led_r || led_g) bad++;
    end
    check("blue_held", bad, 0);
    set_mode(3'b001, 5'b0, 0);
    tick(1);
    check("blue_off_lag", {31'b0, led_b}, 32'd1);
    tick(1);
    check("blue_off", {31'b0, led_b}, 32'd0);
    tick(20);

    // Right turn aborted by red at cycle 10.
    set_mode(3'b011, 5'b0, 0);
    tick(10);
    set_mode(3'b100, 5'b00100, DISPLAY);
    tick(2);
    check("red_on", {29'b0, led_r, motor_l_dir, motor_r_dir}, 32'd7);
    tick(45);
    check("red_done_seen", q.size(), 0);

    // Change lands on the terminal-count cycle: no done pulse.
    set_mode(3'b011, 5'b0, 0);
    tick(TURN);
    check("right_active", {31'b0, motor_r_dir}, 32'd0);
    set_mode(3'b000, 5'b0, 0);
    tick(30);

    // Green interrupted by an asynchronous reset.
    set_mode(3'b110, 5'b0, 0);
    tick(15);
    check("green_on", {31'b0, led_g}, 32'd1);
    reset = 1'b1;
    mode  = 3'b000;
    #1;
    check("async_reset", {20'b0, outs()}, {20'b0, RESET_VEC});
    tick(3);
    check("reset_held", {20'b0, outs()}, {20'b0, RESET_VEC});
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (outs() !== RESET_VEC) bad++;
    end
    check("post_reset_idle", bad, 0);
    check("pending_done", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
